softmax_head_sched: RTL and testbench

//  Round-robin scheduler sharing one softmax unit among NUM_HEAD attention-head score streams.

---
 rtl/softmax_head_sched.sv | 188 ++++++++++++++++++
 tb/tb_softmax_head_sched.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/softmax_head_sched.sv
// Round-robin owner of a shared softmax unit: grants one head, streams its score row in,
// routes the row's results back to it, and admits LUT writes only while idle.
module softmax_head_sched #(
  parameter int SOFTMAX_NUM = 64,
  parameter int NUM_HEAD    = 8,
  parameter int DATA_W      = 8,
  parameter int LUT_ADDR    = 16,
  parameter int LUT_DATA    = 16,
  localparam int CNT_W      = $clog2(SOFTMAX_NUM + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_HEAD-1:0]        req,
  input  logic [CNT_W-1:0]           cfg_row_len,
  input  logic [DATA_W*NUM_HEAD-1:0] in_data,
  input  logic [NUM_HEAD-1:0]        in_valid,
  output logic [NUM_HEAD-1:0]        in_ready,
  output logic [DATA_W-1:0]          sm_idata,
  output logic                       sm_idata_valid,
  input  logic [DATA_W-1:0]          sm_odata,
  input  logic                       sm_odata_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [NUM_HEAD-1:0]        out_valid,
  output logic [NUM_HEAD-1:0]        done,
  output logic [NUM_HEAD-1:0]        grant,
  input  logic                       lut_wen_in,
  input  logic [LUT_ADDR-1:0]        lut_waddr_in,
  input  logic [LUT_DATA-1:0]        lut_wdata_in,
  output logic                       sm_lut_wen,
  output logic [LUT_ADDR-1:0]        sm_lut_waddr,
  output logic [LUT_DATA-1:0]        sm_lut_wdata,
  output logic [1:0]                 err,
  output logic [1:0]                 dbg_state
);
  localparam int HW  = (NUM_HEAD > 1) ? $clog2(NUM_HEAD) : 1;
  localparam int HW1 = HW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                state_q;
  logic [NUM_HEAD-1:0]   grant_q;
  logic [HW-1:0]         gidx_q;
  logic [HW-1:0]         rr_q;
  logic [CNT_W-1:0]      len_q;
  logic [CNT_W-1:0]      in_cnt_q;
  logic [CNT_W-1:0]      out_cnt_q;
  logic [DATA_W-1:0]     sm_idata_q;
  logic                  sm_idata_valid_q;
  logic [DATA_W-1:0]     out_data_q;
  logic [NUM_HEAD-1:0]   out_valid_q;
  logic [NUM_HEAD-1:0]   done_q;
  logic                  sm_lut_wen_q;
  logic [LUT_ADDR-1:0]   sm_lut_waddr_q;
  logic [LUT_DATA-1:0]   sm_lut_wdata_q;
  logic [1:0]            err_q;

  logic [HW:0]           cand;
  logic                  pick_found;
  logic [HW-1:0]         pick_idx;
  logic [CNT_W-1:0]      len_d;
  logic [HW-1:0]         rr_d;
  logic                  feed;
  logic                  hs;
  logic                  res_ok;
  logic                  stray;
  logic                  lut_ok;
  logic [DATA_W-1:0]     cur_data;

  // First requesting head at or after the rr pointer, wrapping.
  always_comb begin
    cand       = '0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NUM_HEAD; i++) begin
      cand = {1'b0, rr_q} + HW1'(i);
      if (cand >= HW1'(NUM_HEAD)) cand = cand - HW1'(NUM_HEAD);
      if (!pick_found && req[cand[HW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[HW-1:0];
      end
    end
  end

  assign len_d = (cfg_row_len == '0 || cfg_row_len > CNT_W'(SOFTMAX_NUM)) ?
                 CNT_W'(SOFTMAX_NUM) : cfg_row_len;
  assign rr_d  = (gidx_q == HW'(NUM_HEAD - 1)) ? '0 : gidx_q + HW'(1);

  // Score handshake: a beat moves on the clock edge where the granted head holds
  // in_valid high while in_ready is high; in_ready depends only on registered state.
  assign feed     = (state_q == S_FEED);
  assign in_ready = feed ? grant_q : '0;
  assign hs       = feed & in_valid[gidx_q];
  assign cur_data = in_data[gidx_q*DATA_W +: DATA_W];

  assign res_ok = sm_odata_valid & (state_q == S_FEED || state_q == S_DRAIN) & (out_cnt_q < len_q);
  assign stray  = sm_odata_valid & ~res_ok;
  assign lut_ok = lut_wen_in & (state_q == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      grant_q          <= '0;
      gidx_q           <= '0;
      rr_q             <= '0;
      len_q            <= '0;
      in_cnt_q         <= '0;
      out_cnt_q        <= '0;
      sm_idata_q       <= '0;
      sm_idata_valid_q <= 1'b0;
      out_data_q       <= '0;
      out_valid_q      <= '0;
      done_q           <= '0;
      sm_lut_wen_q     <= 1'b0;
      sm_lut_waddr_q   <= '0;
      sm_lut_wdata_q   <= '0;
      err_q            <= '0;
    end else begin
      sm_idata_valid_q <= hs;
      if (hs) sm_idata_q <= cur_data;

      out_valid_q <= res_ok ? grant_q : '0;
      if (res_ok) begin
        out_data_q <= sm_odata;
        out_cnt_q  <= out_cnt_q + 1'b1;
      end

      sm_lut_wen_q <= lut_ok;
      if (lut_ok) begin
        sm_lut_waddr_q <= lut_waddr_in;
        sm_lut_wdata_q <= lut_wdata_in;
      end

      if (stray) err_q[0] <= 1'b1;
      if (lut_wen_in && state_q != S_IDLE) err_q[1] <= 1'b1;

      done_q <= '0;
      case (state_q)
        S_IDLE: begin
          // A LUT write takes the idle cycle; arbitration waits one cycle.
          if (!lut_wen_in && pick_found) begin
            grant_q   <= NUM_HEAD'(1) << pick_idx;
            gidx_q    <= pick_idx;
            len_q     <= len_d;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            state_q   <= S_FEED;
          end
        end
        S_FEED: begin
          if (hs) begin
            in_cnt_q <= in_cnt_q + 1'b1;
            if (in_cnt_q == len_q - 1'b1) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (out_cnt_q == len_q) begin
            done_q  <= grant_q;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          grant_q <= '0;
          rr_q    <= rr_d;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sm_idata       = sm_idata_q;
  assign sm_idata_valid = sm_idata_valid_q;
  assign out_data       = out_data_q;
  assign out_valid      = out_valid_q;
  assign done           = done_q;
  assign grant          = grant_q;
  assign sm_lut_wen     = sm_lut_wen_q;
  assign sm_lut_waddr   = sm_lut_waddr_q;
  assign sm_lut_wdata   = sm_lut_wdata_q;
  assign err            = err_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_softmax_head_sched.sv
// Bench for softmax_head_sched: table of round-robin rows, hand-built corner sequences and
// random rows against a queue-based model; the bench also plays the softmax unit.
module tb_softmax_head_sched;
  localparam int NH = 8;
  localparam int DW = 8;
  localparam int CW = 7;

  logic            clk;
  logic            rst_n;
  logic [NH-1:0]   req;
  logic [CW-1:0]   cfg_row_len;
  logic [DW*NH-1:0] in_data;
  logic [NH-1:0]   in_valid;
  logic [NH-1:0]   in_ready;
  logic [DW-1:0]   sm_idata;
  logic            sm_idata_valid;
  logic [DW-1:0]   sm_odata;
  logic            sm_odata_valid;
  logic [DW-1:0]   out_data;
  logic [NH-1:0]   out_valid;
  logic [NH-1:0]   done;
  logic [NH-1:0]   grant;
  logic            lut_wen_in;
  logic [15:0]     lut_waddr_in;
  logic [15:0]     lut_wdata_in;
  logic            sm_lut_wen;
  logic [15:0]     sm_lut_waddr;
  logic [15:0]     sm_lut_wdata;
  logic [1:0]      err;
  logic [1:0]      dbg_state;

  softmax_head_sched dut (
    .clk(clk), .rst_n(rst_n), .req(req), .cfg_row_len(cfg_row_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sm_idata(sm_idata), .sm_idata_valid(sm_idata_valid),
    .sm_odata(sm_odata), .sm_odata_valid(sm_odata_valid),
    .out_data(out_data), .out_valid(out_valid), .done(done), .grant(grant),
    .lut_wen_in(lut_wen_in), .lut_waddr_in(lut_waddr_in), .lut_wdata_in(lut_wdata_in),
    .sm_lut_wen(sm_lut_wen), .sm_lut_waddr(sm_lut_waddr), .sm_lut_wdata(sm_lut_wdata),
    .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [NH-1:0] req;
    int            cfg;
    logic [NH-1:0] exp_g;
    int            exp_len;
  } vec_t;

  vec_t          tbl[18];
  int            total = 0;
  int            bad = 0;
  int            ptr = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_in_q[$];
  logic [DW-1:0] resp_q[$];
  logic [NH-1:0] cur_grant = '0;
  int            n_in, n_out, sent_cnt, tail_len;
  bit            stray_pend = 0;
  bit            stray_tail_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // stand-in softmax transfer function
  function automatic logic [DW-1:0] sm_f(input logic [DW-1:0] x);
    return {x[3:0], x[7:4]} ^ 8'h3C;
  endfunction

  function automatic int pick(input int p, input logic [NH-1:0] m);
    for (int i = 0; i < NH; i++)
      if (m[(p + i) % NH]) return (p + i) % NH;
    return 0;
  endfunction

  function automatic int elen(input int cfg);
    return (cfg == 0 || cfg > 64) ? 64 : cfg;
  endfunction

  // One cycle: scoreboard the DUT outputs, then drive the softmax result port.
  task automatic tick();
    @(negedge clk);
    if (sm_idata_valid) begin
      n_in++;
      if (exp_in_q.size() == 0) begin
        total++; bad++;
        $display("FAIL idata_extra: got %0h want none", sm_idata);
      end else check("sm_idata", sm_idata, exp_in_q.pop_front());
      resp_q.push_back(sm_f(sm_idata));
    end
    if (out_valid != '0) begin
      n_out++;
      check("out_valid_head", out_valid, cur_grant);
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL out_extra: got %0h want none", out_data);
      end else check("out_data", out_data, exp_q.pop_front());
    end
    if (stray_pend) begin
      sm_odata_valid = 1'b1;
      sm_odata       = 8'hEE;
      stray_pend     = 0;
    end else if (resp_q.size() > 0 && $urandom_range(0, 3) != 0) begin
      sm_odata_valid = 1'b1;
      sm_odata       = resp_q.pop_front();
      sent_cnt++;
      if (stray_tail_en && resp_q.size() == 0 && sent_cnt == tail_len) stray_pend = 1;
    end else begin
      sm_odata_valid = 1'b0;
      sm_odata       = 8'($urandom);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0; cfg_row_len = '0; in_data = '0; in_valid = '0;
    lut_wen_in = 1'b0; lut_waddr_in = '0; lut_wdata_in = '0;
    sm_odata = '0; sm_odata_valid = 1'b0;
    resp_q.delete(); exp_q.delete(); exp_in_q.delete();
    stray_pend = 0; stray_tail_en = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    ptr = 0;
    tick();
  endtask

  // driver: one full row for the expected head, with optional corner-case injections
  task automatic run_row(input logic [NH-1:0] mask, input int cfg, input logic [NH-1:0] exp_g,
                         input int el, input bit seq, input bit drop, input bit lut_first,
                         input bit lut_mid, input bit tail, input int rst_at);
    int eh, wc, k, guard;
    bit v, poked;
    logic [DW-1:0] sc;
    eh = 0;
    for (int i = 0; i < NH; i++) if (exp_g[i]) eh = i;
    exp_q.delete(); exp_in_q.delete();
    n_in = 0; n_out = 0; sent_cnt = 0; tail_len = el; stray_tail_en = tail;
    cur_grant = exp_g;
    req = mask;
    cfg_row_len = CW'(cfg);
    if (lut_first) begin
      lut_wen_in = 1'b1; lut_waddr_in = 16'h1234; lut_wdata_in = 16'hBEEF;
    end
    tick();
    wc = 1;
    if (lut_first) begin
      check("lut_fwd_wen", sm_lut_wen, 1);
      check("lut_fwd_addr", sm_lut_waddr, 16'h1234);
      check("lut_fwd_data", sm_lut_wdata, 16'hBEEF);
      check("lut_blocks_grant", grant, 0);
      lut_wen_in = 1'b0;
    end
    while (grant == '0 && wc < 20) begin
      tick();
      wc++;
    end
    check("grant", grant, exp_g);
    check("grant_latency", wc, lut_first ? 2 : 1);
    if (drop) req = '0;
    k = 0; guard = 0; poked = 0;
    while (k < el && guard < 4000) begin
      if (rst_at >= 0 && k == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_grant", grant, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_idata_valid", sm_idata_valid, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        in_valid = '0; req = '0;
        resp_q.delete(); exp_q.delete(); exp_in_q.delete();
        tick();
        rst_n = 1'b1;
        ptr = 0;
        tick();
        check("rst_no_done", done, 0);
        return;
      end
      if (guard == 0) check("in_ready_granted_only", in_ready, exp_g);
      v  = ($urandom_range(0, 3) != 0);
      sc = seq ? DW'(k + 1) : DW'($urandom);
      in_valid = NH'($urandom);
      in_data  = {$urandom, $urandom};
      in_valid[eh] = v;
      in_data[eh*DW +: DW] = sc;
      lut_wen_in = lut_mid && !poked && k == 1;
      if (lut_wen_in) check("err1_before", err[1], 0);
      if (v && in_ready[eh]) begin
        exp_in_q.push_back(sc);
        exp_q.push_back(sm_f(sc));
        k++;
      end
      tick();
      guard++;
      if (lut_wen_in) begin
        poked = 1;
        lut_wen_in = 1'b0;
        check("lut_feed_blocked", sm_lut_wen, 0);
        check("lut_feed_err1", err[1], 1);
      end
    end
    in_valid = '0;
    if (guard >= 4000) begin
      total++; bad++;
      $display("FAIL feed_timeout: got %0d beats want %0d", k, el);
    end
    wc = 0;
    while (done == '0 && wc < 3000) begin
      tick();
      wc++;
    end
    check("done", done, exp_g);
    check("in_count", n_in, el);
    check("out_count", n_out, el);
    if (tail) check("err0_tail", err[0], 1);
    req = '0;
    tick();
    check("done_one_pulse", done, 0);
    check("grant_idle", grant, 0);
    ptr = (eh + 1) % NH;
    stray_tail_en = 0;
  endtask

  initial begin
    int cfg, eh;
    logic [NH-1:0] mask;

    for (int i = 0; i < 8; i++) tbl[i] = '{8'hFF, 2, NH'(1 << i), 2};
    tbl[8]  = '{8'hFF, 2,   8'h01, 2};
    tbl[9]  = '{8'h01, 1,   8'h01, 1};
    tbl[10] = '{8'h81, 3,   8'h80, 3};
    tbl[11] = '{8'h81, 5,   8'h01, 5};
    tbl[12] = '{8'h24, 2,   8'h04, 2};
    tbl[13] = '{8'h24, 3,   8'h20, 3};
    tbl[14] = '{8'h24, 2,   8'h04, 2};
    tbl[15] = '{8'h04, 4,   8'h04, 4};
    tbl[16] = '{8'h10, 0,   8'h10, 64};
    tbl[17] = '{8'h10, 100, 8'h10, 64};

    rst_n = 1'b0;
    req = '0; cfg_row_len = '0; in_data = '0; in_valid = '0;
    lut_wen_in = 1'b0; lut_waddr_in = '0; lut_wdata_in = '0;
    sm_odata = '0; sm_odata_valid = 1'b0;
    @(negedge clk);
    check("reset_grant", grant, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_idata_valid", sm_idata_valid, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_done", done, 0);
    check("reset_lut_wen", sm_lut_wen, 0);
    check("reset_err", err, 0);
    check("reset_out_data", out_data, 0);
    do_reset();

    // stray result while idle
    stray_pend = 1;
    tick();
    tick();
    check("stray_idle_err0", err[0], 1);
    check("stray_idle_no_out", out_valid, 0);

    for (int i = 0; i < 18; i++)
      run_row(tbl[i].req, tbl[i].cfg, tbl[i].exp_g, tbl[i].exp_len, 1, 0, 0, 0, 0, -1);

    do_reset();
    run_row(8'h08, 3, 8'h08, 3, 1, 0, 1, 0, 0, -1);
    check("lut_idle_no_err1", err[1], 0);
    run_row(8'h08, 4, 8'h08, 4, 0, 0, 0, 1, 0, -1);
    run_row(8'h30, 2, 8'h10, 2, 0, 0, 0, 0, 1, -1);

    for (int r = 0; r < 30; r++) begin
      mask = NH'($urandom_range(1, 255));
      if ($urandom_range(0, 9) == 0) cfg = (r % 2 == 1) ? 0 : int'($urandom_range(65, 127));
      else cfg = int'($urandom_range(1, 9));
      eh = pick(ptr, mask);
      run_row(mask, cfg, NH'(1 << eh), elen(cfg), 0, bit'($urandom_range(0, 1)), 0, 0, 0, -1);
      repeat ($urandom_range(0, 3)) tick();
    end

    // reset in the middle of a row, then arbitration restarts at head 0
    run_row(8'h40, 8, 8'h40, 8, 1, 0, 0, 0, 0, 3);
    run_row(8'hFF, 2, NH'(1 << pick(ptr, 8'hFF)), 2, 1, 0, 0, 0, 0, -1);
    check("restart_head0_ptr", ptr, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
